// File: rtl/rcvfifo_mc_pkg.sv
// Shared constants for the multi-channel receive FIFO block.
// Holds the wishbone register offsets, the channel window layout, STAT bit
// positions, the CTRL flush bit and the DROP saturation value.
package rcvfifo_mc_pkg;

  localparam int unsigned ADR_W   = 7;
  localparam int unsigned WB_DW   = 32;
  localparam int unsigned DROP_W  = 16;

  localparam logic [ADR_W-1:0] ADR_CTRL = 7'd0;
  localparam logic [ADR_W-1:0] ADR_OVF  = 7'd1;
  localparam logic [ADR_W-1:0] ADR_IRQ  = 7'd2;
  localparam logic [ADR_W-1:0] ADR_INFO = 7'd3;
  localparam logic [ADR_W-1:0] CH_BASE  = 7'd4;
  localparam int unsigned      CH_STRIDE = 4;

  localparam logic [1:0] OFS_STAT = 2'd0;
  localparam logic [1:0] OFS_DATA = 2'd1;
  localparam logic [1:0] OFS_DROP = 2'd2;

  localparam int unsigned STAT_OVF_BIT   = 31;
  localparam int unsigned STAT_FULL_BIT  = 30;
  localparam int unsigned STAT_EMPTY_BIT = 29;
  localparam int unsigned CTRL_FLUSH_BIT = 31;

  localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

  // Assemble a channel STAT word from its flags and the zero-extended count.
  function automatic logic [WB_DW-1:0] stat_word(input logic ovf, input logic full,
                                                 input logic empty, input logic [15:0] cnt);
    logic [WB_DW-1:0] w;
    w                 = 32'(cnt);
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    return w;
  endfunction

endpackage

// File: rtl/rcvfifo_mc_fifo.sv
// sync_fifo_cnt: single-clock FIFO with occupancy count.
// Ports: clk, rst (sync, active-high), clr (flush: drop contents, ignore the
// write in that cycle), wr_en/wr_dat push, rd_en pop, rd_dat_c combinational
// head word, count (registered occupancy), full_c/empty_c flags, drop_c
// strobe for a push refused because the FIFO is full.
module sync_fifo_cnt #(
  parameter int unsigned DW         = 16,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_dat,
  input  logic                  rd_en,
  output logic [DW-1:0]         rd_dat_c,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full_c,
  output logic                  empty_c,
  output logic                  drop_c
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_acc_c;
  logic                  rd_acc_c;

  assign full_c   = (count == CW'(DEPTH));
  assign empty_c  = (count == '0);
  assign rd_dat_c = mem[rd_ptr];

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign rd_acc_c = rd_en & ~empty_c & ~clr;
  assign wr_acc_c = wr_en & (~full_c | rd_acc_c) & ~clr;
  assign drop_c   = wr_en & full_c & ~rd_acc_c & ~clr & ~rst;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_acc_c) mem[wr_ptr] <= wr_dat;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc_c) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcvfifo_mc.sv
// rcvfifo_mc: NCH receive streams, each buffered in its own FIFO, exposed
// through one wishbone slave (status, data pop, drop counters, threshold
// interrupt, global flush).
// Ports: wb_clk/wb_rst (sync, active-high), wb_cyc/wb_stb/wb_we/wb_adr/
// wb_dat_i access inputs, wb_dat_o registered read data, wb_ack one-cycle
// ack, rx_dat/rx_vld per-channel receive words, irq level interrupt.
module rcvfifo_mc
  import rcvfifo_mc_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DW         = 16,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [6:0]        wb_adr,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack,
  input  logic [NCH*DW-1:0] rx_dat,
  input  logic [NCH-1:0]    rx_vld,
  output logic              irq
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic [DW-1:0]     fifo_dat_c [NCH];
  logic [CW-1:0]     fifo_cnt   [NCH];
  logic [NCH-1:0]    fifo_full_c;
  logic [NCH-1:0]    fifo_empty_c;
  logic [NCH-1:0]    fifo_drop_c;
  logic [NCH-1:0]    pop_c;
  logic [NCH-1:0]    drop_rd_c;
  logic [NCH-1:0]    ovf_clr_c;
  logic [NCH-1:0]    pending_c;
  logic [NCH-1:0]    ovf;
  logic [DROP_W-1:0] drop_cnt [NCH];
  logic [15:0]       threshold;
  logic              flush;
  logic              acc_c;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic              in_ch_c;
  logic [6:0]        rel_c;
  logic [4:0]        ch_sel_c;
  logic [1:0]        ofs_c;
  logic [31:0]       rd_mux_c;
  logic              unused_dat;

  assign unused_dat = ^wb_dat_i[30:16];

  // Access decode: channel window starts at CH_BASE, CH_STRIDE words each.
  assign acc_c     = wb_cyc & wb_stb & ~wb_ack;
  assign rd_acc_c  = acc_c & ~wb_we;
  assign wr_acc_c  = acc_c & wb_we;
  assign in_ch_c   = (wb_adr >= CH_BASE);
  assign rel_c     = wb_adr - CH_BASE;
  assign ch_sel_c  = 5'(rel_c / 7'(CH_STRIDE));
  assign ofs_c     = 2'(rel_c % 7'(CH_STRIDE));
  assign ovf_clr_c = (wr_acc_c && wb_adr == ADR_OVF) ? wb_dat_i[NCH-1:0] : '0;

  // Per-channel FIFOs.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sync_fifo_cnt #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk      (wb_clk),
      .rst      (wb_rst),
      .clr      (flush),
      .wr_en    (rx_vld[g]),
      .wr_dat   (rx_dat[g*DW +: DW]),
      .rd_en    (pop_c[g]),
      .rd_dat_c (fifo_dat_c[g]),
      .count    (fifo_cnt[g]),
      .full_c   (fifo_full_c[g]),
      .empty_c  (fifo_empty_c[g]),
      .drop_c   (fifo_drop_c[g])
    );
  end

  // Read mux, pop / drop-clear requests and per-channel pending flags.
  always_comb begin
    pop_c     = '0;
    drop_rd_c = '0;
    pending_c = '0;
    rd_mux_c  = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      pending_c[c] = (threshold != 16'h0) && (16'(fifo_cnt[c]) >= threshold);
      if (in_ch_c && ch_sel_c == 5'(c)) begin
        case (ofs_c)
          OFS_STAT: rd_mux_c = stat_word(ovf[c], fifo_full_c[c], fifo_empty_c[c], 16'(fifo_cnt[c]));
          OFS_DATA: if (!fifo_empty_c[c]) rd_mux_c = 32'(fifo_dat_c[c]);
          OFS_DROP: rd_mux_c = 32'(drop_cnt[c]);
          default:  rd_mux_c = '0;
        endcase
        pop_c[c]     = rd_acc_c && ofs_c == OFS_DATA && !fifo_empty_c[c];
        drop_rd_c[c] = rd_acc_c && ofs_c == OFS_DROP;
      end
    end
    if (!in_ch_c) begin
      case (wb_adr)
        ADR_CTRL: rd_mux_c = {16'h0, threshold};
        ADR_OVF:  rd_mux_c = 32'(ovf);
        ADR_IRQ:  rd_mux_c = 32'(pending_c);
        ADR_INFO: rd_mux_c = {8'h0, 8'(NCH), 8'(DW), 8'(DEPTH_LOG2)};
        default:  rd_mux_c = '0;
      endcase
    end
  end

  // Bus response, control register, flush pulse and interrupt.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack    <= 1'b0;
      wb_dat_o  <= '0;
      threshold <= '0;
      flush     <= 1'b0;
      irq       <= 1'b0;
    end else begin
      wb_ack <= acc_c;
      flush  <= wr_acc_c && wb_adr == ADR_CTRL && wb_dat_i[CTRL_FLUSH_BIT];
      irq    <= |pending_c;
      if (wr_acc_c && wb_adr == ADR_CTRL) threshold <= wb_dat_i[15:0];
      if (rd_acc_c) wb_dat_o <= rd_mux_c;
    end
  end

  // Sticky overflow flags: a new overflow beats a concurrent clear.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || flush) ovf <= '0;
    else                 ovf <= (ovf & ~ovf_clr_c) | fifo_drop_c;
  end

  // Saturating drop counters, cleared by read; a drop racing the read leaves 1.
  always_ff @(posedge wb_clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (wb_rst || flush) begin
        drop_cnt[c] <= '0;
      end else if (drop_rd_c[c]) begin
        drop_cnt[c] <= fifo_drop_c[c] ? 16'd1 : 16'd0;
      end else if (fifo_drop_c[c] && drop_cnt[c] != DROP_SAT) begin
        drop_cnt[c] <= drop_cnt[c] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rcvfifo_mc.sv
// Bench for rcvfifo_mc: register vector table, directed multi-cycle
// sequences, then random traffic checked against a queue-based model.
module tb_rcvfifo_mc;

  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int DL    = 9;
  localparam int DEPTH = 1 << DL;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [6:0]        wb_adr;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack;
  logic [NCH*DW-1:0] rx_dat;
  logic [NCH-1:0]    rx_vld;
  logic              irq;

  rcvfifo_mc #(.NCH(NCH), .DW(DW), .DEPTH_LOG2(DL)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack   (wb_ack),
    .rx_dat   (rx_dat),
    .rx_vld   (rx_vld),
    .irq      (irq)
  );

  always #5 wb_clk = ~wb_clk;

  int total = 0;
  int bad   = 0;

  logic ack_seen;
  logic irq_at_ack;

  // Reference model state.
  logic [15:0]    mq [NCH][$];
  logic [NCH-1:0] m_ovf;
  int             m_drop [NCH];
  logic [15:0]    m_thr;

  typedef struct {
    logic        we;
    logic [6:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One bus access starting at a negedge; optional rx push in the accept cycle.
  task automatic xfer(input logic we, input logic [6:0] adr, input logic [31:0] dat,
                      input logic [NCH-1:0] pv, input logic [NCH*DW-1:0] pd,
                      output logic [31:0] rd);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    rx_vld = pv; rx_dat = pd;
    @(posedge wb_clk); @(negedge wb_clk);
    ack_seen = wb_ack; irq_at_ack = irq; rd = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; rx_vld = '0;
    @(posedge wb_clk); @(negedge wb_clk);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, adr, 32'h0, '0, '0, r);
    chk({name, "_ack"}, 32'(ack_seen), 32'h1);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [6:0] adr, input logic [31:0] dat);
    logic [31:0] r;
    xfer(1'b1, adr, dat, '0, '0, r);
    chk("wr_ack", 32'(ack_seen), 32'h1);
  endtask

  task automatic push(input int ch, input logic [15:0] w);
    rx_vld = '0;
    rx_vld[ch] = 1'b1;
    rx_dat[ch*DW +: DW] = w;
    @(posedge wb_clk); @(negedge wb_clk);
    rx_vld = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge wb_clk); @(negedge wb_clk); end
  endtask

  function automatic logic [NCH-1:0] m_pend();
    logic [NCH-1:0] p;
    for (int c = 0; c < NCH; c++)
      p[c] = (m_thr != 16'h0) && (mq[c].size() >= int'(m_thr));
    return p;
  endfunction

  function automatic void m_push(input int c, input logic [15:0] w);
    if (mq[c].size() < DEPTH) mq[c].push_back(w);
    else begin
      m_ovf[c] = 1'b1;
      if (m_drop[c] < 65535) m_drop[c]++;
    end
  endfunction

  function automatic void m_write(input logic [6:0] adr, input logic [31:0] d);
    if (adr == 7'd0) begin
      m_thr = d[15:0];
      if (d[31]) begin
        for (int c = 0; c < NCH; c++) begin mq[c].delete(); m_drop[c] = 0; end
        m_ovf = '0;
      end
    end else if (adr == 7'd1) begin
      m_ovf = m_ovf & ~d[NCH-1:0];
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [6:0] adr);
    logic [31:0] v;
    int c, o, n;
    v = '0;
    if (adr == 7'd0)      v = {16'h0, m_thr};
    else if (adr == 7'd1) v = 32'(m_ovf);
    else if (adr == 7'd2) v = 32'(m_pend());
    else if (adr == 7'd3) v = {8'h0, 8'(NCH), 8'(DW), 8'(DL)};
    else begin
      c = (int'(adr) - 4) / 4;
      o = (int'(adr) - 4) % 4;
      if (c < NCH) begin
        n = mq[c].size();
        if (o == 0)      v = {m_ovf[c], n == DEPTH, n == 0, 13'h0, 16'(n)};
        else if (o == 1) begin if (n > 0) v = 32'(mq[c].pop_front()); end
        else if (o == 2) begin v = 32'(m_drop[c]); m_drop[c] = 0; end
      end
    end
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [NCH-1:0] pv;
    logic [NCH*DW-1:0] pd;
    int k;
    logic [6:0] adr;
    logic [31:0] d;

    wb_rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_i = '0; rx_dat = '0; rx_vld = '0;

    vt[0]  = '{1'b0, 7'd3,   32'h0,        32'h0004_1009};
    vt[1]  = '{1'b0, 7'd4,   32'h0,        32'h2000_0000};
    vt[2]  = '{1'b0, 7'd8,   32'h0,        32'h2000_0000};
    vt[3]  = '{1'b0, 7'd12,  32'h0,        32'h2000_0000};
    vt[4]  = '{1'b0, 7'd16,  32'h0,        32'h2000_0000};
    vt[5]  = '{1'b0, 7'd0,   32'h0,        32'h0};
    vt[6]  = '{1'b0, 7'd1,   32'h0,        32'h0};
    vt[7]  = '{1'b0, 7'd2,   32'h0,        32'h0};
    vt[8]  = '{1'b0, 7'd5,   32'h0,        32'h0};
    vt[9]  = '{1'b0, 7'd6,   32'h0,        32'h0};
    vt[10] = '{1'b0, 7'd7,   32'h0,        32'h0};
    vt[11] = '{1'b0, 7'd20,  32'h0,        32'h0};
    vt[12] = '{1'b0, 7'd127, 32'h0,        32'h0};
    vt[13] = '{1'b1, 7'd0,   32'h7FFF_1234, 32'h0};
    vt[14] = '{1'b0, 7'd0,   32'h0,        32'h0000_1234};
    vt[15] = '{1'b1, 7'd2,   32'hFFFF_FFFF, 32'h0};
    vt[16] = '{1'b0, 7'd2,   32'h0,        32'h0};
    vt[17] = '{1'b1, 7'd0,   32'h0,        32'h0};
    vt[18] = '{1'b0, 7'd0,   32'h0,        32'h0};

    // Reset state.
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    chk("rst_ack", 32'(wb_ack), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    wb_rst = 1'b0;

    // Register vector table.
    for (int i = 0; i < 19; i++) begin
      xfer(vt[i].we, vt[i].adr, vt[i].wdat, '0, '0, r);
      chk($sformatf("vec%0d_ack", i), 32'(ack_seen), 32'h1);
      if (!vt[i].we) chk($sformatf("vec%0d", i), r, vt[i].exp);
    end

    // Three words through ch1, then an empty read.
    push(1, 16'h1111); push(1, 16'h2222); push(1, 16'h3333);
    rd_chk("ch1_stat3", 7'd8, 32'h0000_0003);
    rd_chk("ch1_d0", 7'd9, 32'h0000_1111);
    rd_chk("ch1_d1", 7'd9, 32'h0000_2222);
    rd_chk("ch1_d2", 7'd9, 32'h0000_3333);
    rd_chk("ch1_dempty", 7'd9, 32'h0);
    rd_chk("ch1_stat0", 7'd8, 32'h2000_0000);

    // Threshold interrupt on ch3.
    wr(7'd0, 32'h4);
    for (int i = 0; i < 4; i++) push(3, 16'(32'h3000 + i));
    chk("irq_lat0", 32'(irq), 32'h0);
    idle(1);
    chk("irq_rise", 32'(irq), 32'h1);
    rd_chk("irq_vec", 7'd2, 32'h8);
    rd_chk("ch3_pop", 7'd17, 32'h0000_3000);
    chk("irq_at_pop", 32'(irq_at_ack), 32'h1);
    chk("irq_fall", 32'(irq), 32'h0);
    wr(7'd0, 32'h0);

    // Overfill ch2 by 8 words.
    for (int i = 0; i < 520; i++) push(2, 16'(32'h2000 + i));
    rd_chk("ch2_stat_full", 7'd12, 32'hC000_0200);
    rd_chk("ch2_drop", 7'd14, 32'h8);
    rd_chk("ch2_drop_clr", 7'd14, 32'h0);
    rd_chk("ovf_vec", 7'd1, 32'h4);
    wr(7'd1, 32'h4);
    rd_chk("ovf_w1c", 7'd1, 32'h0);
    rd_chk("ch2_stat_noovf", 7'd12, 32'h4000_0200);

    // Full ch0: concurrent pop and push.
    for (int i = 0; i < 512; i++) push(0, 16'(32'hA000 + i));
    rd_chk("ch0_full", 7'd4, 32'h4000_0200);
    pd = '0; pd[15:0] = 16'hBEEF;
    xfer(1'b0, 7'd5, 32'h0, 4'b0001, pd, r);
    chk("popwr_ack", 32'(ack_seen), 32'h1);
    chk("popwr_dat", r, 32'h0000_A000);
    rd_chk("popwr_stat", 7'd4, 32'h4000_0200);
    rd_chk("popwr_drop", 7'd6, 32'h0);
    rd_chk("popwr_ovf", 7'd1, 32'h0);
    push(0, 16'hDEAD);
    rd_chk("ch0_ovf", 7'd1, 32'h1);

    // Flush with data everywhere, rx traffic in the flush cycle.
    wr(7'd0, 32'h5);
    chk("irq_pre_flush", 32'(irq), 32'h1);
    push(1, 16'h0101); push(1, 16'h0202);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 7'd0; wb_dat_i = 32'h8000_0005;
    @(posedge wb_clk); @(negedge wb_clk);
    chk("flush_ack", 32'(wb_ack), 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    rx_vld = '1; rx_dat = {32'($urandom), 32'($urandom)};
    @(posedge wb_clk); @(negedge wb_clk);
    rx_vld = '0;
    idle(1);
    chk("flush_irq", 32'(irq), 32'h0);
    for (int c = 0; c < NCH; c++) begin
      rd_chk($sformatf("flush_stat%0d", c), 7'(4 + 4 * c), 32'h2000_0000);
      rd_chk($sformatf("flush_drop%0d", c), 7'(6 + 4 * c), 32'h0);
    end
    rd_chk("flush_ovf", 7'd1, 32'h0);
    rd_chk("flush_thr", 7'd0, 32'h5);

    // Reset during an access.
    push(1, 16'h5555); push(1, 16'h6666);
    wr(7'd0, 32'h3);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 7'd9; wb_rst = 1'b1;
    @(posedge wb_clk); @(negedge wb_clk);
    chk("rstacc_ack", 32'(wb_ack), 32'h0);
    chk("rstacc_dat", wb_dat_o, 32'h0);
    chk("rstacc_irq", 32'(irq), 32'h0);
    wb_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge wb_clk); @(negedge wb_clk);
    chk("rstacc_ack2", 32'(wb_ack), 32'h0);
    rd_chk("rstacc_stat1", 7'd8, 32'h2000_0000);
    rd_chk("rstacc_thr", 7'd0, 32'h0);

    // Random traffic against the model (DUT is freshly reset here).
    for (int c = 0; c < NCH; c++) begin mq[c].delete(); m_drop[c] = 0; end
    m_ovf = '0; m_thr = '0;
    for (int it = 0; it < 600; it++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        pv = NCH'($urandom);
        pd = {32'($urandom), 32'($urandom)};
        rx_vld = pv; rx_dat = pd;
        @(posedge wb_clk); @(negedge wb_clk);
        rx_vld = '0;
        for (int c = 0; c < NCH; c++) if (pv[c]) m_push(c, pd[c*DW +: DW]);
      end else begin
        k = $urandom_range(0, 9);
        if (k == 0) begin
          d = {($urandom_range(0, 29) == 0), 15'($urandom), 16'($urandom_range(0, 6))};
          m_write(7'd0, d);
          wr(7'd0, d);
        end else if (k == 1) begin
          d = $urandom;
          m_write(7'd1, d);
          wr(7'd1, d);
        end else begin
          adr = (k == 2) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 23));
          rd_chk($sformatf("rnd_rd_a%0d", adr), adr, m_read(adr));
        end
        idle(1);
        chk("rnd_irq", 32'(irq), 32'(|m_pend()));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
